// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the 10-bit teaching CPU.
// Optional feature macro: INSTR_FETCH_JUMP_FOLD_EN (resolve jumps inside fetch).
package cpu_isa_pkg;

    localparam int ADDR_W     = 10;
    localparam int INSTR_W    = 10;
    localparam int JUMP_TGT_W = 7;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_RTYPE = 3'b000;
    localparam opcode_t OP_ADDI  = 3'b011;
    localparam opcode_t OP_JUMP  = 3'b100;
    localparam opcode_t OP_BEQ   = 3'b101;
    localparam opcode_t OP_LOAD  = 3'b110;
    localparam opcode_t OP_STORE = 3'b111;

    localparam logic [INSTR_W-1:0] HALT_WORD = 10'b0010000010;

`ifdef INSTR_FETCH_JUMP_FOLD_EN
    localparam bit JUMP_FOLD_EN = 1'b1;
`else
    localparam bit JUMP_FOLD_EN = 1'b0;
`endif

    // One-entry fetch register handed to decode.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               valid;
    } fetch_reg_t;

    function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1:INSTR_W-3];
    endfunction

    function automatic logic [ADDR_W-1:0] jump_target(input logic [INSTR_W-1:0] w);
        return {{(ADDR_W-JUMP_TGT_W){1'b0}}, w[JUMP_TGT_W-1:0]};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next_sel.sv
// Next-PC selection for the fetch stage: branch redirect, folded jump, or pc+1.
// Jump folding follows INSTR_FETCH_JUMP_FOLD_EN via cpu_isa_pkg::JUMP_FOLD_EN.
module pc_next_sel
    import cpu_isa_pkg::*;
(
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               is_halt,
    output logic               fold_jump
);

    logic is_jump;

    assign is_jump   = (get_opcode(rom_data) == OP_JUMP);
    assign is_halt   = (rom_data == HALT_WORD);
    assign fold_jump = JUMP_FOLD_EN && is_jump;

    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (br_taken)
            next_pc = br_target;
        else if (fold_jump)
            next_pc = jump_target(rom_data);
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, registers the ROM word for decode, handles stall/redirect/halt.
// Build option: define INSTR_FETCH_JUMP_FOLD_EN to resolve jumps here with no bubble.
module instr_fetch
    import cpu_isa_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    fetch_reg_t        fr;
    logic              is_halt;
    logic              fold_jump;

    pc_next_sel u_pc_next_sel (
        .pc        (pc),
        .rom_data  (rom_data),
        .br_taken  (br_taken),
        .br_target (br_target),
        .next_pc   (next_pc),
        .is_halt   (is_halt),
        .fold_jump (fold_jump)
    );

    // Priority: halted freezes everything (redirects included), then redirect, then stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            fr     <= '0;
            halted <= 1'b0;
        end else if (halted) begin
            fr.valid <= 1'b0;
        end else if (br_taken) begin
            pc       <= next_pc;
            fr.valid <= 1'b0;
        end else if (!stall) begin
            if (is_halt) begin
                fr     <= '{instr: rom_data, pc: pc, valid: 1'b1};
                halted <= 1'b1;
            end else if (fold_jump) begin
                pc       <= next_pc;
                fr.valid <= 1'b0;
            end else begin
                fr <= '{instr: rom_data, pc: pc, valid: 1'b1};
                pc <= next_pc;
            end
        end
    end

    assign rom_addr    = pc;
    assign instr       = fr.instr;
    assign instr_pc    = fr.pc;
    assign instr_valid = fr.valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a cycle-level ISA fetch model.
// Follows INSTR_FETCH_JUMP_FOLD_EN the same way the design does.
module tb_instr_fetch;

`ifdef INSTR_FETCH_JUMP_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif
    localparam logic [9:0] HALT = 10'b0010000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rom_addr;
    logic [9:0] rom_data;
    logic       stall = 1'b0;
    logic       br_taken = 1'b0;
    logic [9:0] br_target = '0;
    logic [9:0] instr;
    logic [9:0] instr_pc;
    logic       instr_valid;
    logic       halted;

    logic [9:0] rom [0:1023];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [9:0] m_pc, m_instr, m_ipc;
    logic       m_valid, m_halted;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 10'd0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // One clock edge of the fetch stage, straight from the ISA-level rules.
    task automatic model_step(input logic st, input logic br, input logic [9:0] tgt);
        logic [9:0] w;
        w = rom[m_pc];
        if (m_halted) begin
            m_valid = 1'b0;
        end else if (br) begin
            m_pc = tgt; m_valid = 1'b0;
        end else if (st) begin
            // hold
        end else if (w == HALT) begin
            m_instr = w; m_ipc = m_pc; m_valid = 1'b1; m_halted = 1'b1;
        end else if (FOLD && w[9:7] == 3'b100) begin
            m_pc = {3'b000, w[6:0]}; m_valid = 1'b0;
        end else begin
            m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
            m_pc = 10'((32'(m_pc) + 1) % 1024);
        end
    endtask

    task automatic check_all();
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        if (m_valid) begin
            chk("instr", 32'(instr), 32'(m_instr));
            chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
        end
    endtask

    task automatic cycle(input logic st, input logic br, input logic [9:0] tgt);
        stall = st; br_taken = br; br_target = tgt;
        @(posedge clk); #1;
        model_step(st, br, tgt);
        check_all();
    endtask

    // Called 1ns after a rising edge; asserts reset mid-cycle and releases before the next edge.
    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] seq [4];
        logic [9:0] w;
        seq[0] = 10'd0; seq[1] = 10'b1101110000; seq[2] = 10'b1101101101; seq[3] = 10'b0000101001;

        // random ROM with no stray halts; 4..46 kept free of jumps for the directed walk
        for (int i = 0; i < 1024; i++) begin
            do w = 10'($urandom);
            while (w == HALT || (i >= 4 && i <= 46 && w[9:7] == 3'b100) || (i == 1023 && w[9:7] == 3'b100));
            rom[i] = w;
        end
        for (int i = 0; i < 4; i++) rom[i] = seq[i];
        rom[7]  = 10'b1000001001;
        rom[47] = HALT;

        model_reset();
        @(posedge clk); #1;
        async_reset();

        // free-run over words 0..3
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, '0);
            chk("seq_instr", 32'(instr), 32'(seq[i]));
            chk("seq_pc", 32'(instr_pc), 32'(i));
            chk("seq_valid", 32'(instr_valid), 32'd1);
        end

        // reach instr_pc=4, then stall 3 edges
        cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0);
            chk("stall_pc", 32'(instr_pc), 32'd4);
            chk("stall_instr", 32'(instr), 32'(rom[4]));
            chk("stall_addr", 32'(rom_addr), 32'd5);
        end
        cycle(1'b0, 1'b0, '0);
        chk("resume_pc", 32'(instr_pc), 32'd5);
        cycle(1'b0, 1'b0, '0);
        chk("pre_jump_pc", 32'(instr_pc), 32'd6);
        cycle(1'b0, 1'b0, '0);
        if (FOLD) begin
            chk("fold_bubble", 32'(instr_valid), 32'd0);
            cycle(1'b0, 1'b0, '0);
            chk("fold_target", 32'(instr_pc), 32'd9);
        end else begin
            chk("jump_fwd_instr", 32'(instr), 32'b1000001001);
            chk("jump_fwd_pc", 32'(instr_pc), 32'd7);
            cycle(1'b0, 1'b0, '0);
            chk("jump_next_pc", 32'(instr_pc), 32'd8);
        end

        // redirect under stall
        cycle(1'b1, 1'b1, 10'd25);
        chk("br_bubble", 32'(instr_valid), 32'd0);
        chk("br_addr", 32'(rom_addr), 32'd25);
        cycle(1'b0, 1'b0, '0);
        chk("br_land", 32'(instr_pc), 32'd25);

        // halt at 47
        cycle(1'b0, 1'b1, 10'd47);
        cycle(1'b0, 1'b0, '0);
        chk("halt_pc", 32'(instr_pc), 32'd47);
        chk("halt_valid", 32'(instr_valid), 32'd1);
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1, 10'($urandom));
            chk("halt_hold_addr", 32'(rom_addr), 32'd47);
            chk("halt_hold_valid", 32'(instr_valid), 32'd0);
        end
        async_reset();

        // wrap at 1023
        cycle(1'b0, 1'b1, 10'd1023);
        cycle(1'b0, 1'b0, '0);
        chk("wrap_pc", 32'(instr_pc), 32'd1023);
        chk("wrap_addr", 32'(rom_addr), 32'd0);
        cycle(1'b0, 1'b0, '0);
        async_reset();

        // random mix
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), 10'($urandom));
            if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0)
                async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
